// File: rtl/load_pkg.sv
// Shared definitions for the load alignment datapath: mode encodings, FSM states
// and the size / legality helpers used by both the control and extension logic.
package load_pkg;

  localparam logic [2:0] NOREGWRITE = 3'd0;
  localparam logic [2:0] LB         = 3'd1;
  localparam logic [2:0] LH         = 3'd2;
  localparam logic [2:0] LW         = 3'd3;
  localparam logic [2:0] LBU        = 3'd4;
  localparam logic [2:0] LHU        = 3'd5;
  localparam logic [2:0] LWU        = 3'd6;
  localparam logic [2:0] LD         = 3'd7;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE0,
    DATA0,
    DATA1,
    RESP
  } state_t;

  function automatic logic [3:0] load_size(input logic [2:0] mode);
    case (mode)
      LB, LBU: load_size = 4'd1;
      LH, LHU: load_size = 4'd2;
      LW, LWU: load_size = 4'd4;
      LD:      load_size = 4'd8;
      default: load_size = 4'd0;
    endcase
  endfunction

  // Doubleword and unsigned-word loads only exist on a 64-bit datapath.
  function automatic logic mode_legal(input logic [2:0] mode, input int xlen);
    mode_legal = !((xlen == 32) && ((mode == LWU) || (mode == LD)));
  endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational byte select and sign/zero extension of a two-word little-endian window.
// Zero latency, no handshake.
module load_extend
  import load_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0]         din,
  input  logic [$clog2(XLEN/8)-1:0] offset,
  input  logic [2:0]                mode,
  output logic [XLEN-1:0]           dout
);

  logic [XLEN-1:0] shifted;

  // Only the low word of the shifted window can ever hold selected bytes.
  assign shifted = XLEN'(din >> {offset, 3'b000});

  always_comb begin
    dout = '0;
    case (mode)
      LB:      dout = XLEN'($signed(shifted[7:0]));
      LH:      dout = XLEN'($signed(shifted[15:0]));
      LW:      dout = XLEN'($signed(shifted[31:0]));
      LBU:     dout = XLEN'(shifted[7:0]);
      LHU:     dout = XLEN'(shifted[15:0]);
      LWU:     dout = XLEN'(shifted[31:0]);
      LD:      dout = shifted;
      default: dout = '0;
    endcase
  end

endmodule

// File: rtl/load_align_unit.sv
// Sequential load unit: one or two aligned memory reads, stitching, then extension.
// Latency 3 (aligned) / 4 (split) / 1 (no access); result held in RESP until resp_ready.
module load_align_unit
  import load_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int ADDR_W      = 32,
  parameter int MISALIGN_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_mode,
  input  logic [4:0]        req_rd,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_data,
  output logic [4:0]        resp_rd,
  output logic              resp_fault,
  output logic              busy
);

  localparam int BYTES = XLEN / 8;
  localparam int OFF_W = $clog2(BYTES);

  state_t state, state_nxt;

  logic              accept, resp_fire;
  logic [4:0]        span_sum;
  logic              req_spans, req_fault, needs_mem;
  logic [OFF_W-1:0]  off_q;
  logic [2:0]        mode_q;
  logic              span_q;
  logic [XLEN-1:0]   word0_q;
  logic [2*XLEN-1:0] ext_din;
  logic [XLEN-1:0]   ext_data;

  assign req_ready = (state == IDLE) && !rst;
  assign busy      = (state != IDLE);
  assign accept    = req_valid && req_ready;
  assign resp_fire = resp_valid && resp_ready;

  assign span_sum  = 5'(req_addr[OFF_W-1:0]) + 5'(load_size(req_mode));
  assign req_spans = span_sum > 5'(BYTES);
  assign req_fault = !mode_legal(req_mode, XLEN) || (req_spans && (MISALIGN_EN == 0));
  assign needs_mem = !req_fault && (req_mode != NOREGWRITE);

  // Upper word reads as zero for loads that stay within one word.
  assign ext_din = span_q ? {mem_rdata, word0_q} : {{XLEN{1'b0}}, mem_rdata};

  load_extend #(.XLEN(XLEN)) u_extend (
    .din    (ext_din),
    .offset (off_q),
    .mode   (mode_q),
    .dout   (ext_data)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = needs_mem ? ISSUE0 : RESP;
      ISSUE0:  state_nxt = DATA0;
      DATA0:   state_nxt = span_q ? DATA1 : RESP;
      DATA1:   state_nxt = RESP;
      RESP:    if (resp_fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_rd_en  <= 1'b0;
      mem_addr   <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_rd    <= '0;
      resp_fault <= 1'b0;
      off_q      <= '0;
      mode_q     <= NOREGWRITE;
      span_q     <= 1'b0;
      word0_q    <= '0;
    end else begin
      mem_rd_en <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            off_q   <= req_addr[OFF_W-1:0];
            mode_q  <= req_mode;
            span_q  <= req_spans;
            resp_rd <= req_rd;
            if (needs_mem) begin
              mem_rd_en <= 1'b1;
              mem_addr  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            end else begin
              resp_valid <= 1'b1;
              resp_data  <= '0;
              resp_fault <= req_fault;
            end
          end
        end
        // Second read is launched early so it lands in the cycle after word0.
        ISSUE0: begin
          if (span_q) begin
            mem_rd_en <= 1'b1;
            mem_addr  <= mem_addr + ADDR_W'(BYTES);
          end
        end
        DATA0: begin
          word0_q <= mem_rdata;
          if (!span_q) begin
            resp_valid <= 1'b1;
            resp_data  <= ext_data;
            resp_fault <= 1'b0;
          end
        end
        DATA1: begin
          resp_valid <= 1'b1;
          resp_data  <= ext_data;
          resp_fault <= 1'b0;
        end
        RESP: begin
          if (resp_fire) resp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_align_unit.sv
// Bench for load_align_unit across three configurations: 32-bit split-capable,
// 32-bit fault-on-misalign and 64-bit split-capable.
module tb_load_align_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid  [3];
  logic        req_ready  [3];
  logic [31:0] req_addr   [3];
  logic [2:0]  req_mode   [3];
  logic [4:0]  req_rd     [3];
  logic        mem_rd_en  [3];
  logic [31:0] mem_addr   [3];
  logic [63:0] mem_rdata  [3];
  logic        resp_valid [3];
  logic        resp_ready [3];
  logic [63:0] resp_data  [3];
  logic [4:0]  resp_rd    [3];
  logic        resp_fault [3];
  logic        busy       [3];

  logic [31:0] rdat0, rdat1;
  logic [63:0] rdat2;
  assign resp_data[0] = 64'(rdat0);
  assign resp_data[1] = 64'(rdat1);
  assign resp_data[2] = rdat2;

  load_align_unit #(.XLEN(32), .ADDR_W(32), .MISALIGN_EN(1)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_addr(req_addr[0]), .req_mode(req_mode[0]), .req_rd(req_rd[0]),
    .mem_rd_en(mem_rd_en[0]), .mem_addr(mem_addr[0]), .mem_rdata(mem_rdata[0][31:0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_data(rdat0),
    .resp_rd(resp_rd[0]), .resp_fault(resp_fault[0]), .busy(busy[0]));

  load_align_unit #(.XLEN(32), .ADDR_W(32), .MISALIGN_EN(0)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_addr(req_addr[1]), .req_mode(req_mode[1]), .req_rd(req_rd[1]),
    .mem_rd_en(mem_rd_en[1]), .mem_addr(mem_addr[1]), .mem_rdata(mem_rdata[1][31:0]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_data(rdat1),
    .resp_rd(resp_rd[1]), .resp_fault(resp_fault[1]), .busy(busy[1]));

  load_align_unit #(.XLEN(64), .ADDR_W(32), .MISALIGN_EN(1)) dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_addr(req_addr[2]), .req_mode(req_mode[2]), .req_rd(req_rd[2]),
    .mem_rd_en(mem_rd_en[2]), .mem_addr(mem_addr[2]), .mem_rdata(mem_rdata[2]),
    .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]), .resp_data(rdat2),
    .resp_rd(resp_rd[2]), .resp_fault(resp_fault[2]), .busy(busy[2]));

  int passed = 0;
  int total  = 0;

  // Byte-addressed backing store; unwritten bytes come from a fixed hash.
  logic [7:0] mem_b [logic [31:0]];

  function automatic int xl_of(input int d);
    return (d == 2) ? 64 : 32;
  endfunction

  function automatic int men_of(input int d);
    return (d == 1) ? 0 : 1;
  endfunction

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    if (mem_b.exists(a)) return mem_b[a];
    return 8'(a[7:0] * 8'd37) ^ a[15:8] ^ 8'hC3;
  endfunction

  function automatic logic [63:0] word_at(input int xl, input logic [31:0] wa);
    logic [63:0] w = '0;
    for (int k = 0; k < xl / 8; k++) w[8*k +: 8] = rd_byte(wa + 32'(k));
    return w;
  endfunction

  task automatic write_word(input int d, input logic [31:0] wa, input logic [63:0] wd);
    for (int k = 0; k < xl_of(d) / 8; k++) mem_b[wa + 32'(k)] = wd[8*k +: 8];
  endtask

  // Synchronous memory: data valid only the cycle after a read strobe, junk otherwise.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++)
      mem_rdata[i] <= mem_rd_en[i] ? word_at(xl_of(i), mem_addr[i]) : {$urandom, $urandom};
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    else passed++;
  endtask

  // Reference: assemble the loaded value byte by byte from memory.
  task automatic model(input int d, input logic [31:0] addr, input logic [2:0] mode,
                       output logic [63:0] data, output logic fault, output int lat,
                       output int nrd, output logic [31:0] a0, output logic [31:0] a1);
    int xl, bytes, size, off;
    logic [63:0] v;
    xl = xl_of(d);
    bytes = xl / 8;
    size = (mode == 1 || mode == 4) ? 1 : (mode == 2 || mode == 5) ? 2 :
           (mode == 3 || mode == 6) ? 4 : (mode == 7) ? 8 : 0;
    off = int'(addr[2:0]) % bytes;
    a0 = addr - 32'(off);
    a1 = a0 + 32'(bytes);
    data = '0; fault = 1'b0; lat = 1; nrd = 0;
    if (mode == 0) return;
    if (xl == 32 && mode >= 6) begin fault = 1'b1; return; end
    if (off + size > bytes && men_of(d) == 0) begin fault = 1'b1; return; end
    nrd = (off + size > bytes) ? 2 : 1;
    lat = nrd + 2;
    v = '0;
    for (int k = 0; k < size; k++) v[8*k +: 8] = rd_byte(addr + 32'(k));
    if (mode <= 3 && size * 8 < xl && v[8*size-1]) v = v | ~((64'd1 << (8*size)) - 64'd1);
    if (xl == 32) v[63:32] = '0;
    data = v;
  endtask

  task automatic do_load(input int d, input logic [31:0] addr, input logic [2:0] mode,
                         input logic [4:0] rd, input int hold, input logic [63:0] ed,
                         input logic ef, input int el, input int en, input logic [31:0] ea0,
                         input logic [31:0] ea1, input string nm);
    int lat, guard;
    logic [31:0] ra[$];
    logic [63:0] sd;
    logic sf, stable;
    logic [4:0] srd;
    guard = 0;
    while (!req_ready[d] && guard < 20) begin @(negedge clk); guard++; end
    chk({nm, "_req_ready"}, 64'(req_ready[d]), 64'd1);
    resp_ready[d] = (hold == 0);
    req_valid[d] = 1'b1; req_addr[d] = addr; req_mode[d] = mode; req_rd[d] = rd;
    @(negedge clk);
    req_valid[d] = 1'b0; req_addr[d] = $urandom; req_mode[d] = 3'($urandom);
    lat = 1;
    while (!resp_valid[d] && lat < 20) begin
      if (mem_rd_en[d]) ra.push_back(mem_addr[d]);
      @(negedge clk);
      lat++;
    end
    if (mem_rd_en[d]) ra.push_back(mem_addr[d]);
    chk({nm, "_latency"}, 64'(lat), 64'(el));
    chk({nm, "_data"}, resp_data[d], ed);
    chk({nm, "_fault"}, 64'(resp_fault[d]), 64'(ef));
    chk({nm, "_rd"}, 64'(resp_rd[d]), 64'(rd));
    sd = resp_data[d]; sf = resp_fault[d]; srd = resp_rd[d]; stable = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (resp_valid[d] !== 1'b1 || resp_data[d] !== sd || resp_fault[d] !== sf ||
          resp_rd[d] !== srd || req_ready[d] !== 1'b0 || busy[d] !== 1'b1 || mem_rd_en[d])
        stable = 1'b0;
    end
    if (hold > 0) chk({nm, "_hold_stable"}, 64'(stable), 64'd1);
    chk({nm, "_nreads"}, 64'(ra.size()), 64'(en));
    for (int i = 0; i < ra.size() && i < 2; i++)
      chk($sformatf("%s_rdaddr%0d", nm, i), 64'(ra[i]), 64'(i == 0 ? ea0 : ea1));
    resp_ready[d] = 1'b1;
    @(negedge clk);
    chk({nm, "_idle_after"}, 64'({resp_valid[d], busy[d], req_ready[d]}), 64'b001);
  endtask

  typedef struct {
    string nm; int d; logic [31:0] addr; logic [2:0] mode; int hold; int nw;
    logic [31:0] wa0; logic [63:0] wd0; logic [31:0] wa1; logic [63:0] wd1;
    logic [63:0] ed; logic ef; int el; int en; logic [31:0] ea0; logic [31:0] ea1;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string nm, input int d, input logic [31:0] addr, input logic [2:0] mode,
                     input int hold, input int nw, input logic [31:0] wa0, input logic [63:0] wd0,
                     input logic [31:0] wa1, input logic [63:0] wd1, input logic [63:0] ed,
                     input logic ef, input int el, input int en, input logic [31:0] ea0,
                     input logic [31:0] ea1);
    vec_t v;
    v.nm = nm; v.d = d; v.addr = addr; v.mode = mode; v.hold = hold; v.nw = nw;
    v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
    v.ed = ed; v.ef = ef; v.el = el; v.en = en; v.ea0 = ea0; v.ea1 = ea1;
    vecs.push_back(v);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      req_valid[i] = 1'b0; req_addr[i] = '0; req_mode[i] = '0; req_rd[i] = '0;
      resp_ready[i] = 1'b1;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++)
      chk($sformatf("reset_state_d%0d", i),
          {req_ready[i], resp_valid[i], resp_fault[i], mem_rd_en[i], busy[i],
           resp_rd[i], mem_addr[i], 25'd0} | resp_data[i], 64'd0);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++)
      chk($sformatf("ready_after_reset_d%0d", i), 64'({req_ready[i], busy[i], mem_rd_en[i]}), 64'b100);

    add("lb_neg",       0, 32'h103, 3'd1, 0, 1, 32'h100, 64'h80123456, 0, 0, 64'hFFFFFF80, 0, 3, 1, 32'h100, 0);
    add("lhu_split",    0, 32'h103, 3'd5, 0, 2, 32'h100, 64'hAABBCCDD, 32'h104, 64'h11223344, 64'h44AA, 0, 4, 2, 32'h100, 32'h104);
    add("lw_wrap",      0, 32'hFFFFFFFE, 3'd3, 0, 2, 32'hFFFFFFFC, 64'h55667788, 32'h0, 64'h11223344, 64'h33445566, 0, 4, 2, 32'hFFFFFFFC, 32'h0);
    add("lw_misal_flt", 1, 32'h102, 3'd3, 0, 0, 0, 0, 0, 0, 64'h0, 1, 1, 0, 0, 0);
    add("ld_x32_flt",   1, 32'h100, 3'd7, 0, 0, 0, 0, 0, 0, 64'h0, 1, 1, 0, 0, 0);
    add("ld_x32_flt_m", 0, 32'h100, 3'd7, 0, 0, 0, 0, 0, 0, 64'h0, 1, 1, 0, 0, 0);
    add("lwu_x32_flt",  0, 32'h100, 3'd6, 0, 0, 0, 0, 0, 0, 64'h0, 1, 1, 0, 0, 0);
    add("noregwrite",   0, 32'h101, 3'd0, 0, 0, 0, 0, 0, 0, 64'h0, 0, 1, 0, 0, 0);
    add("lw_m0_align",  1, 32'h104, 3'd3, 0, 1, 32'h104, 64'h12345678, 0, 0, 64'h12345678, 0, 3, 1, 32'h104, 0);
    add("lwu_x64",      2, 32'h100, 3'd6, 0, 1, 32'h100, 64'h80000000, 0, 0, 64'h0000000080000000, 0, 3, 1, 32'h100, 0);
    add("lw_x64",       2, 32'h100, 3'd3, 0, 1, 32'h100, 64'h80000000, 0, 0, 64'hFFFFFFFF80000000, 0, 3, 1, 32'h100, 0);
    add("ld_x64_split", 2, 32'h104, 3'd7, 0, 2, 32'h100, 64'h8877665544332211, 32'h108, 64'h00FFEEDDCCBBAA99, 64'hCCBBAA9988776655, 0, 4, 2, 32'h100, 32'h108);
    add("lh_neg",       0, 32'h102, 3'd2, 0, 1, 32'h100, 64'h80123456, 0, 0, 64'hFFFF8012, 0, 3, 1, 32'h100, 0);
    add("lbu_hold",     0, 32'h101, 3'd4, 4, 1, 32'h100, 64'h80123456, 0, 0, 64'h34, 0, 3, 1, 32'h100, 0);
    add("flt_hold",     1, 32'h103, 3'd2, 4, 0, 0, 0, 0, 0, 64'h0, 1, 1, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].nw >= 1) write_word(vecs[i].d, vecs[i].wa0, vecs[i].wd0);
      if (vecs[i].nw >= 2) write_word(vecs[i].d, vecs[i].wa1, vecs[i].wd1);
      do_load(vecs[i].d, vecs[i].addr, vecs[i].mode, 5'(i + 1), vecs[i].hold, vecs[i].ed,
              vecs[i].ef, vecs[i].el, vecs[i].en, vecs[i].ea0, vecs[i].ea1, vecs[i].nm);
    end

    // Reset while the second read of a split load is on the bus.
    write_word(0, 32'h100, 64'hAABBCCDD);
    write_word(0, 32'h104, 64'h11223344);
    req_valid[0] = 1'b1; req_addr[0] = 32'h102; req_mode[0] = 3'd3; req_rd[0] = 5'd3;
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("rst_mid_second_read", 64'({mem_rd_en[0], busy[0]}), 64'b11);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_quiet", 64'({mem_rd_en[0], resp_valid[0], req_ready[0], busy[0]}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_ready", 64'({req_ready[0], busy[0], resp_valid[0]}), 64'b100);
    write_word(0, 32'h200, 64'h000000F0);
    do_load(0, 32'h200, 3'd1, 5'd21, 0, 64'hFFFFFFF0, 0, 3, 1, 32'h200, 0, "lb_after_rst");

    for (int it = 0; it < 80; it++) begin
      int d, el, en, hold;
      logic [31:0] a, ea0, ea1;
      logic [2:0] m;
      logic [63:0] ed;
      logic ef;
      d = $urandom_range(0, 2);
      case ($urandom_range(0, 3))
        0:       a = 32'h100 + 32'($urandom_range(0, 15));
        1:       a = 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
        2:       a = 32'($urandom_range(0, 7));
        default: a = $urandom;
      endcase
      m = 3'($urandom_range(0, 7));
      hold = $urandom_range(0, 2);
      for (int k = -8; k < 16; k++) mem_b[a + 32'(k)] = 8'($urandom);
      model(d, a, m, ed, ef, el, en, ea0, ea1);
      do_load(d, a, m, 5'($urandom), hold, ed, ef, el, en, ea0, ea1, $sformatf("rnd%0d_d%0d", it, d));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/load_align_unit.md
# load_align_unit

Parametrised, sequential load-data unit between data memory and writeback. Accepts one load request at a time, issues one or two word-aligned reads to a synchronous memory, stitches together accesses that cross a word boundary, then byte-selects and sign/zero-extends to XLEN. It replaces purely combinational load extension, adding 64-bit support, misaligned split loads, fault reporting and a valid/ready result handshake.

## Interface
Parameters:
- XLEN, 32: datapath and memory word width; 32 or 64 only; BYTES = XLEN/8.
- ADDR_W, 32: byte-address width.
- MISALIGN_EN, 1: 1 = boundary-crossing loads are split into two reads; 0 = they fault.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  1  load request valid.
- req_ready  out  1  high only in IDLE while rst is low.
- req_addr  in  ADDR_W  byte address.
- req_mode  in  3  load mode: NOREGWRITE=0, LB=1, LH=2, LW=3, LBU=4, LHU=5, LWU=6, LD=7.
- req_rd  in  5  destination-register tag; returned unchanged.
- mem_rd_en  out  1  read strobe; registered.
- mem_addr  out  ADDR_W  word-aligned read address; low log2(BYTES) bits are 0.
- mem_rdata  in  XLEN  read data; valid exactly one cycle after mem_rd_en.
- resp_valid  out  1  result valid.
- resp_ready  in  1  consumer accepts the result.
- resp_data  out  XLEN  extended load value.
- resp_rd  out  5  tag of the result.
- resp_fault  out  1  illegal mode, or misaligned load with MISALIGN_EN=0.
- busy  out  1  high in every state other than IDLE; used by the hazard unit.

## Operation
- Size: LB/LBU=1, LH/LHU=2, LW/LWU=4, LD=8. Offset is addr mod BYTES. The load spans two words when offset+size > BYTES.
- Sign extension applies to LB, LH, LW (LW only when XLEN=64). LBU, LHU, LWU zero-extend. LD and XLEN-wide LW pass data through unchanged.
- Illegal modes: LWU or LD when XLEN=32. An illegal mode produces resp_fault=1, resp_data=0, and no memory access.
- NOREGWRITE: produces resp_data=0 and resp_fault=0, with no memory access.
- A spanning load with MISALIGN_EN=0 faults with no memory access.
- States:
  - IDLE: wait for request.
  - ISSUE0: drive the read of word floor(addr) and assert mem_rd_en.
  - DATA0: capture word0. If the load spans, issue the read of word0_addr+BYTES and go to DATA1; otherwise go to RESP.
  - DATA1: capture word1, then go to RESP.
  - RESP: hold the result until resp_ready.
- From IDLE, a request that needs no memory access goes directly to RESP.
- Assembly: take {word1, word0} (word1=0 if the load does not span), shift right by offset*8, keep the low size bytes, then extend. Little-endian throughout.
- Second-read address wraps modulo 2^ADDR_W.
- Only one request is outstanding. req_ready is low from acceptance until the cycle after the RESP handshake.
- Reset in any state: next state is IDLE, the transaction is discarded, and no response is produced. Memory data returning after reset is ignored.

## Timing
- Reset values: resp_valid=0, resp_data=0, resp_rd=0, resp_fault=0, mem_rd_en=0, mem_addr=0, busy=0, state=IDLE. req_ready=0 while rst is high and 1 in the first cycle after release.
- With the request accepted at edge T:
  - Aligned load: mem_rd_en high in T+1; resp_valid rises at T+3.
  - Split load: reads in T+1 and T+2; resp_valid rises at T+4.
  - Fault or NOREGWRITE: resp_valid rises at T+1.
- mem_rd_en is a single-cycle pulse per read. There are never more than two reads per request.
- In RESP, resp_valid, resp_data, resp_rd and resp_fault stay stable until resp_valid && resp_ready. IDLE follows on the next edge.
- Sustained throughput is one load per 4 cycles (aligned, resp_ready held high).

## Structure
- Package load_pkg holds:
  - mode constants NOREGWRITE..LD;
  - the state enum;
  - function load_size(mode) returning the byte count;
  - function mode_legal(mode, XLEN).
- Sub-module load_extend: purely combinational, parameter XLEN. Inputs are the 2*XLEN concatenation, offset and mode; output is the extended XLEN result. The FSM, address generation and registers stay in load_align_unit.

## Test plan
- XLEN=32, LB at 0x103, word@0x100=0x80123456 → one read at 0x100, resp_data=0xFFFFFF80, resp_valid at T+3.
- XLEN=32, LHU at 0x103, word@0x100=0xAABBCCDD, word@0x104=0x11223344 → reads 0x100 then 0x104, resp_data=0x000044AA at T+4.
- XLEN=32, LW at 0xFFFFFFFE, word@0xFFFFFFFC=0x55667788, word@0x0=0x11223344 → second read at 0x00000000, resp_data=0x33445566.
- MISALIGN_EN=0, LW at 0x102 → no mem_rd_en, resp_fault=1, resp_data=0 at T+1. Same check for LD with XLEN=32. XLEN=64, LWU of 0x80000000 → 0x0000000080000000.
- Hold resp_ready low for 5 cycles in RESP → outputs stable, req_ready=0, busy=1; handshake → IDLE, and the next request is accepted.
- Assert rst during DATA0 of a split load → mem_rd_en=0 and resp_valid=0 next cycle, req_ready=1 after release; the following LB returns the correct value.
